// File: rtl/hazard_deglitcher.sv
`default_nettype none
// ============================================================================
// Module   : hazard_deglitcher
// Brief    : Synchronizes the raw select-circuit output and filters short
//            pulses with a consecutive-sample stability filter; counts rejects.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_deglitcher #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr_count,
    output logic             dout,
    output logic             changed,
    output logic             glitch_pulse,
    output logic [CNT_W-1:0] glitch_count
);

    localparam int                 c_run_w    = $clog2(STABLE_CYCLES);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

    logic               r_s1;
    logic               r_s2;
    logic               r_dout;
    logic [c_run_w-1:0] r_run_cnt;
    logic               r_changed;
    logic               r_glitch_pulse;
    logic [CNT_W-1:0]   r_glitch_count;

    logic               w_dout_nxt;
    logic [c_run_w-1:0] w_run_nxt;
    logic               w_changed_nxt;
    logic               w_glitch_nxt;
    logic [CNT_W-1:0]   w_count_nxt;

    // State register: synchronizer, filter state and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_dout         <= 1'b0;
            r_run_cnt      <= '0;
            r_changed      <= 1'b0;
            r_glitch_pulse <= 1'b0;
            r_glitch_count <= '0;
        end else begin
            r_s1           <= din;
            r_s2           <= r_s1;
            r_dout         <= w_dout_nxt;
            r_run_cnt      <= w_run_nxt;
            r_changed      <= w_changed_nxt;
            r_glitch_pulse <= w_glitch_nxt;
            r_glitch_count <= w_count_nxt;
        end
    end

    // Next state: a run of differing samples either reaches the limit and is
    // accepted, or ends early and is counted as a rejected glitch.
    always_comb begin
        w_dout_nxt    = r_dout;
        w_run_nxt     = r_run_cnt;
        w_changed_nxt = 1'b0;
        w_glitch_nxt  = 1'b0;
        w_count_nxt   = r_glitch_count;
        if (r_s2 == r_dout) begin
            if (r_run_cnt != '0) begin
                w_run_nxt    = '0;
                w_glitch_nxt = 1'b1;
                if (r_glitch_count != c_cnt_max) begin
                    w_count_nxt = r_glitch_count + 1'b1;
                end
            end
        end else if (r_run_cnt == c_run_last) begin
            w_dout_nxt    = r_s2;
            w_run_nxt     = '0;
            w_changed_nxt = 1'b1;
        end else begin
            w_run_nxt = r_run_cnt + 1'b1;
        end
        // Clear takes priority over a coincident increment.
        if (clr_count) begin
            w_count_nxt = '0;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        dout         = r_dout;
        changed      = r_changed;
        glitch_pulse = r_glitch_pulse;
        glitch_count = r_glitch_count;
    end

endmodule
`default_nettype wire
